// File: rtl/uart_reg_master.sv
// uart_reg_master: turns command frames from a byte-level UART receiver into
// register-bus reads/writes and returns one response byte per frame.
// Command byte: bit7=1 write / 0 read, bits[1:0] address, bits[6:2] must be 0.
// A write frame carries 4 payload bytes, LSB first; a read frame is the
// command byte alone.
module uart_reg_master #(
  parameter int         READ_LATENCY = 1,
  parameter int         TIMEOUT      = 100000,
  parameter logic [7:0] ACK_BYTE     = 8'hA5,
  parameter logic [7:0] ERR_BYTE     = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [1:0]  address,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic        read_enable,
  input  logic [7:0]  read_data,
  output logic        busy,
  output logic        overrun
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);
  // Last RD_WAIT count before read_data is sampled (unused when latency is 0).
  localparam logic [1:0]     LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    BUS_WR   = 3'd2,
    BUS_RD   = 3'd3,
    RD_WAIT  = 3'd4,
    SEND_RSP = 3'd5
  } state_t;

  // A command is legal only when its reserved bits [6:2] are all zero.
  function automatic logic cmd_legal(input logic [7:0] cmd);
    return (cmd[6:2] == 5'd0);
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    address_q, address_d;
  logic [31:0]   write_data_q, write_data_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  // Shared counter: payload byte index in GET_DATA, latency count in RD_WAIT.
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          overrun_q, overrun_d;
  logic          write_enable_s, read_enable_s, tx_start_s;

  // Next-state, datapath updates and one-hot strobe decode.
  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    write_data_d   = write_data_q;
    tx_byte_d      = tx_byte_q;
    cnt_d          = cnt_q;
    tmo_d          = tmo_q;
    overrun_d      = 1'b0;
    write_enable_s = 1'b0;
    read_enable_s  = 1'b0;
    tx_start_s     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        tmo_d = '0;
        if (rx_valid) begin
          if (!cmd_legal(rx_byte)) begin
            tx_byte_d = ERR_BYTE;
            state_d   = SEND_RSP;
          end else if (rx_byte[7]) begin
            address_d = rx_byte[1:0];
            state_d   = GET_DATA;
          end else begin
            address_d = rx_byte[1:0];
            state_d   = BUS_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          // A byte arriving on the timeout cycle still counts as in time.
          tmo_d = '0;
          write_data_d[{cnt_q, 3'b000} +: 8] = rx_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = BUS_WR;
          end else begin
            state_d = GET_DATA;
          end
        end else if (tmo_q >= TMO_MAX) begin
          // Abandon the frame silently; partial payload stays in write_data.
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      BUS_WR: begin
        write_enable_s = 1'b1;
        overrun_d      = rx_valid;
        tx_byte_d      = ACK_BYTE;
        state_d        = SEND_RSP;
      end
      BUS_RD: begin
        read_enable_s = 1'b1;
        overrun_d     = rx_valid;
        cnt_d         = 2'd0;
        if (READ_LATENCY == 0) begin
          tx_byte_d = read_data;
          state_d   = SEND_RSP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        overrun_d = rx_valid;
        if (cnt_q == LAT_LAST) begin
          tx_byte_d = read_data;
          state_d   = SEND_RSP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      SEND_RSP: begin
        overrun_d = rx_valid;
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = SEND_RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      address_q    <= 2'd0;
      write_data_q <= 32'd0;
      tx_byte_q    <= 8'd0;
      cnt_q        <= 2'd0;
      tmo_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      tx_byte_q    <= tx_byte_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      overrun_q    <= overrun_d;
    end
  end

  assign address      = address_q;
  assign write_data   = write_data_q;
  assign tx_byte      = tx_byte_q;
  assign overrun      = overrun_q;
  assign write_enable = write_enable_s;
  assign read_enable  = read_enable_s;
  assign tx_start     = tx_start_s;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: a frame table plus hand-written
// sequences for timeout, tx backpressure/overrun and reset mid-frame.
module tb_uart_reg_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  address;
  logic        write_enable;
  logic [31:0] write_data;
  logic        read_enable;
  logic [7:0]  read_data;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  uart_reg_master #(
    .READ_LATENCY(1),
    .TIMEOUT     (50),
    .ACK_BYTE    (8'hA5),
    .ERR_BYTE    (8'hEE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .address     (address),
    .write_enable(write_enable),
    .write_data  (write_data),
    .read_enable (read_enable),
    .read_data   (read_data),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Event monitor: counts strobes and captures bus/tx values, sampled on negedge.
  int          cyc = 0, n_we = 0, n_re = 0, n_tx = 0, n_ovr = 0, n_multi = 0;
  int          we_cyc = 0, re_cyc = 0, tx_cyc = 0;
  logic [1:0]  we_addr = 2'd0, re_addr = 2'd0;
  logic [31:0] we_data = 32'd0;
  logic [7:0]  tx_cap = 8'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (write_enable) begin
      n_we <= n_we + 1; we_cyc <= cyc; we_addr <= address; we_data <= write_data;
    end
    if (read_enable) begin
      n_re <= n_re + 1; re_cyc <= cyc; re_addr <= address;
    end
    if (tx_start) begin
      n_tx <= n_tx + 1; tx_cyc <= cyc; tx_cap <= tx_byte;
    end
    if (overrun) n_ovr <= n_ovr + 1;
    if ((32'(write_enable) + 32'(read_enable) + 32'(tx_start)) > 32'd1) n_multi <= n_multi + 1;
  end

  typedef struct {
    int              n;
    logic [4:0][7:0] b;
    logic [7:0]      rd;
    logic            exp_we;
    logic [1:0]      exp_addr;
    logic [31:0]     exp_wd;
    logic            exp_re;
    logic [7:0]      exp_tx;
  } vec_t;

  vec_t vecs[7];
  int b_we, b_re, b_tx, b_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_we = n_we; b_re = n_re; b_tx = n_tx; b_ovr = n_ovr;
  endtask

  // Called at posedge+1; presents one byte for exactly one cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    @(posedge clk); #1;
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we",   {31'd0, write_enable}, 32'd0);
    chk("rst_re",   {31'd0, read_enable}, 32'd0);
    chk("rst_txs",  {31'd0, tx_start}, 32'd0);
    chk("rst_ovr",  {31'd0, overrun}, 32'd0);
    chk("rst_addr", {30'd0, address}, 32'd0);
    chk("rst_wd",   write_data, 32'd0);
    chk("rst_txb",  {24'd0, tx_byte}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'd0; tx_busy = 1'b0; read_data = 8'd0;

    vecs[0] = '{n:5, b:{8'h00, 8'h00, 8'h00, 8'h82, 8'h80}, rd:8'h00, exp_we:1'b1, exp_addr:2'd0, exp_wd:32'h00000082, exp_re:1'b0, exp_tx:8'hA5};
    vecs[1] = '{n:1, b:{8'h00, 8'h00, 8'h00, 8'h00, 8'h03}, rd:8'hB4, exp_we:1'b0, exp_addr:2'd3, exp_wd:32'h0, exp_re:1'b1, exp_tx:8'hB4};
    vecs[2] = '{n:1, b:{8'h00, 8'h00, 8'h00, 8'h00, 8'h44}, rd:8'h00, exp_we:1'b0, exp_addr:2'd0, exp_wd:32'h0, exp_re:1'b0, exp_tx:8'hEE};
    vecs[3] = '{n:5, b:{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h83}, rd:8'h00, exp_we:1'b1, exp_addr:2'd3, exp_wd:32'hDEADBEEF, exp_re:1'b0, exp_tx:8'hA5};
    vecs[4] = '{n:1, b:{8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, rd:8'h5A, exp_we:1'b0, exp_addr:2'd1, exp_wd:32'h0, exp_re:1'b1, exp_tx:8'h5A};
    vecs[5] = '{n:1, b:{8'h00, 8'h00, 8'h00, 8'h00, 8'hFC}, rd:8'h00, exp_we:1'b0, exp_addr:2'd0, exp_wd:32'h0, exp_re:1'b0, exp_tx:8'hEE};
    vecs[6] = '{n:1, b:{8'h00, 8'h00, 8'h00, 8'h00, 8'h02}, rd:8'h00, exp_we:1'b0, exp_addr:2'd2, exp_wd:32'h0, exp_re:1'b1, exp_tx:8'h00};

    #3;
    check_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      snap();
      read_data = vecs[v].rd;
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k]);
      wait_idle($sformatf("v%0d_idle", v));
      chk($sformatf("v%0d_nwe", v), n_we - b_we, {31'd0, vecs[v].exp_we});
      chk($sformatf("v%0d_nre", v), n_re - b_re, {31'd0, vecs[v].exp_re});
      chk($sformatf("v%0d_ntx", v), n_tx - b_tx, 32'd1);
      chk($sformatf("v%0d_novr", v), n_ovr - b_ovr, 32'd0);
      chk($sformatf("v%0d_txb", v), {24'd0, tx_cap}, {24'd0, vecs[v].exp_tx});
      if (vecs[v].exp_we) begin
        chk($sformatf("v%0d_waddr", v), {30'd0, we_addr}, {30'd0, vecs[v].exp_addr});
        chk($sformatf("v%0d_wdata", v), we_data, vecs[v].exp_wd);
        chk($sformatf("v%0d_wgap", v), tx_cyc - we_cyc, 32'd1);
      end
      if (vecs[v].exp_re) begin
        chk($sformatf("v%0d_raddr", v), {30'd0, re_addr}, {30'd0, vecs[v].exp_addr});
        chk($sformatf("v%0d_rgap", v), tx_cyc - re_cyc, 32'd2);
      end
    end

    // Timeout: partial frame abandoned silently, next frame completes
    snap();
    send_byte(8'h81);
    send_byte(8'h01);
    repeat (60) @(posedge clk);
    #1;
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_nwe", n_we - b_we, 32'd0);
    chk("tmo_ntx", n_tx - b_tx, 32'd0);
    chk("tmo_partial", write_data[7:0], 32'h01);
    send_byte(8'h81); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_idle("tmo2_idle");
    chk("tmo2_nwe", n_we - b_we, 32'd1);
    chk("tmo2_wdata", we_data, 32'h00000001);
    chk("tmo2_waddr", {30'd0, we_addr}, 32'd1);
    chk("tmo2_ntx", n_tx - b_tx, 32'd1);
    chk("tmo2_txb", {24'd0, tx_cap}, 32'hA5);

    // Backpressure with a dropped byte
    snap();
    tx_busy = 1'b1;
    send_byte(8'h82); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'h55);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_novr", n_ovr - b_ovr, 32'd1);
    chk("bp_ntx_held", n_tx - b_tx, 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    chk("bp_txb", {24'd0, tx_byte}, 32'hA5);
    tx_busy = 1'b0;
    wait_idle("bp_idle");
    chk("bp_ntx", n_tx - b_tx, 32'd1);
    chk("bp_txcap", {24'd0, tx_cap}, 32'hA5);
    chk("bp_wdata", we_data, 32'h44332211);
    chk("bp_nwe", n_we - b_we, 32'd1);

    // Reset mid-frame, then a clean write to address 2
    snap();
    send_byte(8'h82);
    send_byte(8'h69);
    #2 rst = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h82); send_byte(8'h69); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_idle("rst2_idle");
    chk("rst2_nwe", n_we - b_we, 32'd1);
    chk("rst2_waddr", {30'd0, we_addr}, 32'd2);
    chk("rst2_wdata", we_data, 32'h00000069);
    chk("rst2_ntx", n_tx - b_tx, 32'd1);
    chk("rst2_txb", {24'd0, tx_cap}, 32'hA5);

    chk("one_hot_strobes", n_multi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
